// File: rtl/ps2_key_decoder_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 Set-2 key decoder.
//   PS2_EXT / PS2_BRK / PS2_PAUSE : prefix bytes recognised in IDLE
//   PAUSE_LEN                     : bytes swallowed after the E1 that opens Pause
//   dec_state_e                   : decoder FSM state
//   key_evt_t                     : queued key event {ext, rel, code}
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  localparam logic [2:0] PAUSE_LEN = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } dec_state_e;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } key_evt_t;

  localparam int EVT_W = $bits(key_evt_t);

  function automatic key_evt_t mk_evt(input logic ext, input logic rel,
                                      input logic [7:0] code);
    key_evt_t e;
    e.ext  = ext;
    e.rel  = rel;
    e.code = code;
    return e;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if: byte input from the PS/2 receiver plus the key-event
// queue seen by the consumer.
//   data_valid/data_in : raw receiver byte stream (into decoder)
//   rd_en              : consumer pops the head event (into decoder)
//   key_*              : head event of the queue (from decoder)
//   fifo_full/overflow : queue status (from decoder)
//   last_make          : most recent make code (from decoder)
// master = decoder side, slave = receiver/consumer side.
interface ps2_key_decoder_if;
  logic       data_valid;
  logic [7:0] data_in;
  logic       rd_en;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_release;
  logic       key_extended;
  logic       fifo_full;
  logic       overflow;
  logic [7:0] last_make;

  modport master (
    input  data_valid, data_in, rd_en,
    output key_valid, key_code, key_release, key_extended,
           fifo_full, overflow, last_make
  );

  modport slave (
    output data_valid, data_in, rd_en,
    input  key_valid, key_code, key_release, key_extended,
           fifo_full, overflow, last_make
  );
endinterface

// File: rtl/ps2_key_decoder_fifo.sv
// key_fifo: show-ahead FIFO, DEPTH entries of WIDTH bits.
//   ck, reset : clock, async active-low reset (empties the queue)
//   push/din  : write request; accepted when not full, or when full with pop
//   pop       : advance head; ignored when empty
//   dout      : head entry (valid while !empty)
//   empty/full: from registered pointers
module key_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic             ck,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  // one extra pointer bit distinguishes full from empty
  logic [AW:0]                  wr_ptr_q, wr_ptr_d;
  logic [AW:0]                  rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0][WIDTH-1:0]  mem_q, mem_d;
  logic                         do_wr, do_rd;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // a pop frees the slot in the same cycle, so push-while-full succeeds with pop
  assign do_rd = pop & ~empty;
  assign do_wr = push & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_wr) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // storage needs no reset: dout is masked by empty at the top level
  always_ff @(posedge ck) mem_q <= mem_d;

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: folds PS/2 Set-2 scancode sequences (E0 extended, F0 break,
// 8-byte E1 Pause) into single key events queued in a show-ahead FIFO.
//   ck    : system clock
//   reset : async active-low reset
//   bus   : ps2_key_decoder_if.master (receiver bytes in, key events out)
// DEPTH          : FIFO entries (power of two, >= 2)
// TIMEOUT_CYCLES : idle cycles before a partial prefix is abandoned
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic                ck,
  input  logic                reset,
  ps2_key_decoder_if.master   bus
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  dec_state_e     state_q, state_d;
  logic [2:0]     skip_q, skip_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [7:0]     last_make_q, last_make_d;
  logic           overflow_q, overflow_d;
  logic           dv_q;

  logic           byte_stb;
  logic           push;
  key_evt_t       push_evt;
  key_evt_t       head_evt;
  logic [EVT_W-1:0] fifo_dout;
  logic           fifo_empty, fifo_full;

  // one byte per data_valid rising edge, however long it is held
  assign byte_stb = bus.data_valid & ~dv_q;

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    tmo_d    = tmo_q;
    push     = 1'b0;
    push_evt = '0;
    if (byte_stb) begin
      tmo_d = '0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.data_in == PS2_EXT) begin
            state_d = ST_EXT;
          end else if (bus.data_in == PS2_BRK) begin
            state_d = ST_BRK;
          end else if (bus.data_in == PS2_PAUSE) begin
            // Pause reports as a single E1 make; the rest is swallowed
            state_d  = ST_PAUSE;
            skip_d   = PAUSE_LEN;
            push     = 1'b1;
            push_evt = mk_evt(1'b0, 1'b0, bus.data_in);
          end else begin
            push     = 1'b1;
            push_evt = mk_evt(1'b0, 1'b0, bus.data_in);
          end
        end
        ST_EXT: begin
          if (bus.data_in == PS2_BRK) begin
            state_d = ST_EXT_BRK;
          end else begin
            state_d  = ST_IDLE;
            push     = 1'b1;
            push_evt = mk_evt(1'b1, 1'b0, bus.data_in);
          end
        end
        ST_BRK: begin
          state_d  = ST_IDLE;
          push     = 1'b1;
          push_evt = mk_evt(1'b0, 1'b1, bus.data_in);
        end
        ST_EXT_BRK: begin
          state_d  = ST_IDLE;
          push     = 1'b1;
          push_evt = mk_evt(1'b1, 1'b1, bus.data_in);
        end
        ST_PAUSE: begin
          if (skip_q <= 3'd1) begin
            skip_d  = '0;
            state_d = ST_IDLE;
          end else begin
            skip_d = skip_q - 3'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      // stalled mid-sequence: give up on the prefix quietly
      if (tmo_q == TMO_LAST) begin
        state_d = ST_IDLE;
        skip_d  = '0;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  // a dropped make still counts as the latest make
  assign last_make_d = (push && !push_evt.rel) ? push_evt.code : last_make_q;
  assign overflow_d  = overflow_q | (push & fifo_full & ~bus.rd_en);

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      skip_q      <= '0;
      tmo_q       <= '0;
      last_make_q <= '0;
      overflow_q  <= 1'b0;
      dv_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      tmo_q       <= tmo_d;
      last_make_q <= last_make_d;
      overflow_q  <= overflow_d;
      dv_q        <= bus.data_valid;
    end
  end

  key_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .ck    (ck),
    .reset (reset),
    .push  (push),
    .din   (push_evt),
    .pop   (bus.rd_en),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // head fields read as zero when empty (storage is unreset)
  assign head_evt = fifo_empty ? key_evt_t'('0) : key_evt_t'(fifo_dout);

  assign bus.key_valid    = ~fifo_empty;
  assign bus.key_code     = head_evt.code;
  assign bus.key_release  = head_evt.rel;
  assign bus.key_extended = head_evt.ext;
  assign bus.fifo_full    = fifo_full;
  assign bus.overflow     = overflow_q;
  assign bus.last_make    = last_make_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder (DEPTH=4, TIMEOUT_CYCLES=16).
module tb_ps2_key_decoder;

  logic ck    = 1'b0;
  logic reset = 1'b0;

  ps2_key_decoder_if bus();

  ps2_key_decoder #(
    .DEPTH          (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .ck    (ck),
    .reset (reset),
    .bus   (bus)
  );

  always #5 ck = ~ck;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] all_outs();
    return {5'd0, bus.key_valid, bus.key_code, bus.key_release, bus.key_extended,
            bus.fifo_full, bus.overflow, bus.last_make};
  endfunction

  // all drives happen on the falling edge, checks after it
  task automatic send(input logic [7:0] b, input int hold = 1);
    @(negedge ck);
    bus.data_valid = 1'b1;
    bus.data_in    = b;
    repeat (hold) @(negedge ck);
    bus.data_valid = 1'b0;
  endtask

  task automatic expect_pop(input string tag, input logic ext, input logic rel,
                            input logic [7:0] code);
    chk(tag, {21'd0, bus.key_valid, bus.key_extended, bus.key_release, bus.key_code},
        {21'd0, 1'b1, ext, rel, code});
    bus.rd_en = 1'b1;
    @(negedge ck);
    bus.rd_en = 1'b0;
  endtask

  initial begin
    bus.data_valid = 1'b0;
    bus.data_in    = 8'h00;
    bus.rd_en      = 1'b0;

    // reset state
    repeat (3) @(negedge ck);
    chk("reset_outs", all_outs(), 32'd0);
    reset = 1'b1;
    @(negedge ck);

    // make / break
    send(8'h1C);
    chk("mk_valid_1cyc", {31'd0, bus.key_valid}, 32'd1);
    chk("mk_last_make", {24'd0, bus.last_make}, 32'h1C);
    send(8'hF0);
    send(8'h1C);
    expect_pop("mk_ev0", 1'b0, 1'b0, 8'h1C);
    expect_pop("brk_ev1", 1'b0, 1'b1, 8'h1C);
    chk("mkbrk_empty", {31'd0, bus.key_valid}, 32'd0);
    chk("brk_last_make_kept", {24'd0, bus.last_make}, 32'h1C);

    // extended
    send(8'hE0);
    chk("ext_prefix_no_evt", {31'd0, bus.key_valid}, 32'd0);
    send(8'h75);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    expect_pop("ext_make", 1'b1, 1'b0, 8'h75);
    expect_pop("ext_brk", 1'b1, 1'b1, 8'h75);
    chk("ext_empty", {31'd0, bus.key_valid}, 32'd0);

    // pause
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    chk("pause_last_make", {24'd0, bus.last_make}, 32'hE1);
    expect_pop("pause_evt", 1'b0, 1'b0, 8'hE1);
    chk("pause_single", {31'd0, bus.key_valid}, 32'd0);
    send(8'h29);
    expect_pop("after_pause", 1'b0, 1'b0, 8'h29);

    // data_valid held high for 5 cycles
    send(8'h1C, 5);
    expect_pop("held_evt", 1'b0, 1'b0, 8'h1C);
    chk("held_single", {31'd0, bus.key_valid}, 32'd0);

    // short gap keeps the E0 prefix alive
    send(8'hE0);
    repeat (8) @(negedge ck);
    send(8'h1C);
    expect_pop("tmo_short", 1'b1, 1'b0, 8'h1C);

    // long gap abandons it
    send(8'hE0);
    repeat (20) @(negedge ck);
    send(8'h1C);
    expect_pop("tmo_long", 1'b0, 1'b0, 8'h1C);
    chk("tmo_empty", {31'd0, bus.key_valid}, 32'd0);

    // fill / overflow
    send(8'h11); send(8'h12); send(8'h13); send(8'h14);
    chk("full_at_4", {30'd0, bus.fifo_full, bus.overflow}, 32'b10);
    send(8'h15);
    chk("overflow_at_5", {30'd0, bus.fifo_full, bus.overflow}, 32'b11);
    chk("head_kept_11", {24'd0, bus.key_code}, 32'h11);
    // push + pop while full
    @(negedge ck);
    bus.data_valid = 1'b1;
    bus.data_in    = 8'h16;
    bus.rd_en      = 1'b1;
    @(negedge ck);
    bus.data_valid = 1'b0;
    bus.rd_en      = 1'b0;
    chk("simul_head", {23'd0, bus.key_valid, bus.key_code}, {23'd0, 1'b1, 8'h12});
    chk("simul_full_ovf", {30'd0, bus.fifo_full, bus.overflow}, 32'b11);
    expect_pop("rd_12", 1'b0, 1'b0, 8'h12);
    expect_pop("rd_13", 1'b0, 1'b0, 8'h13);
    expect_pop("rd_14", 1'b0, 1'b0, 8'h14);
    expect_pop("rd_16", 1'b0, 1'b0, 8'h16);
    chk("drain_status", {29'd0, bus.key_valid, bus.fifo_full, bus.overflow}, 32'b001);

    // reset mid-sequence
    send(8'h21);
    send(8'hE0);
    @(negedge ck);
    reset = 1'b0;
    #2;
    chk("midreset_outs", all_outs(), 32'd0);
    @(negedge ck);
    reset = 1'b1;
    send(8'h75);
    expect_pop("post_reset_no_ext", 1'b0, 1'b0, 8'h75);
    chk("post_reset_empty", {31'd0, bus.key_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Consumes the raw byte stream from the PS/2 receiver (`ps21`: `data_valid`/`data_out`) and turns PS/2 Set-2 scancode sequences into single key events. It folds the E0 (extended) and F0 (break) prefixes, swallows the 8-byte Pause sequence, and queues events in a small show-ahead FIFO. It sits between the PS/2 receiver and display/application logic such as `transcodor`. It also holds the most recent make code for direct display.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `TIMEOUT_CYCLES`, 500000: idle cycles after which a partial prefix is abandoned (10 ms at 50 MHz).
- `ck` input 1: system clock.
- `reset` input 1: asynchronous, active-low reset.
- `data_valid` input 1: byte-valid from the receiver; may stay high several cycles; one byte per rising edge.
- `data_in` input 8: received byte; sampled only on the `data_valid` rising edge.
- `rd_en` input 1: pop the head entry; ignored when empty.
- `key_valid` output 1: FIFO not empty.
- `key_code` output 8: head entry scancode.
- `key_release` output 1: head entry is a break event.
- `key_extended` output 1: head entry had the E0 prefix.
- `fifo_full` output 1: FIFO holds DEPTH entries.
- `overflow` output 1: sticky; an event was dropped.
- `last_make` output 8: code of the most recent make event.

## Operation
- Edge detect: `dv_d` registers `data_valid`. A byte arrives when `data_valid & ~dv_d`.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE.
  - IDLE: E0 goes to EXT. F0 goes to BRK. E1 goes to PAUSE, loads skip=7 and pushes {ext=0, rel=0, code=E1}. Any other byte pushes {0, 0, byte}.
  - EXT: F0 goes to EXT_BRK. Any other byte pushes {1, 0, byte} and returns to IDLE.
  - BRK: pushes {0, 1, byte} and returns to IDLE.
  - EXT_BRK: pushes {1, 1, byte} and returns to IDLE.
  - PAUSE: each byte decrements skip. When skip reaches 0, return to IDLE. No pushes.
- Prefix bytes inside EXT, BRK or EXT_BRK (E0, F0, E1) are treated as ordinary codes. No nesting.
- Timeout: a counter clears on every byte and increments while the state is not IDLE. At TIMEOUT_CYCLES-1 the FSM returns to IDLE with no push and skip is cleared.
- `last_make` updates to the byte on every push with rel=0, including E1.
- FIFO:
  - Show-ahead; entry is 10 bits {ext, rel, code}.
  - Write and read pointers are log2(DEPTH)+1 bits and wrap naturally.
  - Push and pop in the same cycle: both happen, including when full or empty-with-push. An empty FIFO with push and `rd_en` pops nothing.
  - Push when full without pop: the event is dropped, `overflow` is set, and the FSM still advances.
- `overflow` clears only on reset.

## Timing
- Reset values:
  - All outputs 0: `key_valid`, `key_code`, `key_release`, `key_extended`, `fifo_full`, `overflow`, `last_make`.
  - FSM in IDLE, pointers 0, `dv_d`=0, timeout counter 0.
- Latency: with `data_valid` first sampled high at edge k, the entry is written at edge k. `key_valid` and head fields are valid immediately after edge k.
- Pop: `rd_en` high at edge k advances the head at edge k. The next entry (or `key_valid`=0) is visible after edge k.
- `fifo_full` and `key_valid` are derived from registered pointers, so they are glitch-free relative to `ck`.
- Reset mid-sequence: a pending prefix or pause skip is discarded and the FIFO is emptied.

## Structure
- Package `ps2_pkg`:
  - Constants `PS2_EXT`=8'hE0, `PS2_BRK`=8'hF0, `PS2_PAUSE`=8'hE1, `PAUSE_LEN`=7.
  - FSM state typedef.
  - Event record {ext, rel, code[7:0]}.
- One sub-module, `key_fifo`: parameterised show-ahead FIFO with push/pop/full/empty.
- The top level holds the edge detect, FSM, timeout and `last_make`.

## Test plan
- Make/break: bytes 1C, F0 1C → two events {0,0,1C} then {0,1,1C}; `last_make`=1C; `key_valid` one cycle after the first `data_valid` rise.
- Extended: E0 75, E0 F0 75 → {1,0,75}, {1,1,75}; no events emitted for the prefix bytes.
- Pause: E1 14 77 E1 F0 14 F0 77 → exactly one event {0,0,E1}; a following 29 yields {0,0,29}.
- Held `data_valid`: hold high for 5 cycles with 1C → exactly one event.
- Timeout: send E0 then idle TIMEOUT_CYCLES (test value 16), then send 1C → {0,0,1C} with ext=0.
- Full/overflow (DEPTH=4): push 5 makes (11..15) without reads → `fifo_full`=1, `overflow`=1, reads return 11..14. At full, simultaneous push 16 and pop → head 12, count stays 4, `overflow` unchanged. Assert `reset` mid-stream → all outputs 0.
